// File: rtl/cache_mem_pkg.sv
// Shared types and helpers for the cache-to-word-memory bridge.
package cache_mem_pkg;

  localparam int LINE_W     = 128;
  localparam int BEAT_CNT_W = 2;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WR         = 3'd1,
    RD_ISSUE   = 3'd2,
    RD_COLLECT = 3'd3,
    RESP       = 3'd4
  } bridge_state_t;

  // Word k of a 128-bit line; word k occupies bits [32k+31:32k].
  function automatic logic [31:0] line_word(input logic [LINE_W-1:0] line,
                                            input logic [BEAT_CNT_W-1:0] k);
    return line[32*int'(k) +: 32];
  endfunction

  // Index of the lowest set bit of a 4-bit word-enable mask (0 when empty).
  function automatic logic [BEAT_CNT_W-1:0] first_enabled(input logic [3:0] mask);
    logic [BEAT_CNT_W-1:0] idx;
    idx = '0;
    for (int k = 3; k >= 0; k--) begin
      if (mask[k]) idx = k[BEAT_CNT_W-1:0];
    end
    return idx;
  endfunction

endpackage

// File: rtl/cache_mem_bridge_line_assembler.sv
// Line assembler: gathers returned memory words into a 128-bit line in
// arrival order. 'full' flags the cycle in which the fourth word is being
// captured, so the complete line is visible on 'line' the following cycle.
module line_assembler
  import cache_mem_pkg::*;
#(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              i_mem_rvalid,
  input  logic [WORD_W-1:0] i_mem_rdata,
  output logic [LINE_W-1:0] line,
  output logic              full
);

  logic [BEAT_CNT_W-1:0] ret_cnt;

  // Capture each returned word into slot ret_cnt; clear rewinds the counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_cnt <= '0;
      line    <= '0;
    end else if (clear) begin
      ret_cnt <= '0;
    end else if (i_mem_rvalid) begin
      line[WORD_W*int'(ret_cnt) +: WORD_W] <= i_mem_rdata;
      ret_cnt                              <= ret_cnt + 1'b1;
    end
  end

  assign full = !clear && i_mem_rvalid && (ret_cnt == 2'd3);

endmodule

// File: rtl/cache_mem_bridge.sv
// cache_mem_bridge: splits 128-bit cache line reads/writes into four 32-bit
// beats on a single-port word memory and returns the reassembled line.
// Optional statistics counters are built when BRIDGE_STATS_EN is defined.
// Note: 'rst' is asynchronous and active-low.
//
// Handshakes: cache side accepts a request in any cycle where
// o_s_waitrequest is low (only in IDLE); memory side consumes a beat when
// its strobe (o_mem_re / o_mem_we) is high and i_mem_ready is high, and
// strobe/address/data stay unchanged until then. Read words come back on
// i_mem_rvalid in issue order.
module cache_mem_bridge
  import cache_mem_pkg::*;
#(
  parameter int LINE_ADDR_W = 26,
  parameter int WORD_W      = 32,
  parameter int BEATS       = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_ADDR_W-1:0] i_s_addr,
  input  logic [3:0]             i_s_byte_en,
  input  logic [LINE_W-1:0]      i_s_writedata,
  input  logic                   i_s_read,
  input  logic                   i_s_write,
  output logic [LINE_W-1:0]      o_s_readdata,
  output logic                   o_s_readdata_valid,
  output logic                   o_s_waitrequest,
  output logic [LINE_ADDR_W+1:0] o_mem_addr,
  output logic                   o_mem_re,
  output logic                   o_mem_we,
  output logic [WORD_W-1:0]      o_mem_wdata,
  input  logic                   i_mem_ready,
  input  logic [WORD_W-1:0]      i_mem_rdata,
  input  logic                   i_mem_rvalid,
`ifdef BRIDGE_STATS_EN
  output logic [31:0]            cnt_line_rd,
  output logic [31:0]            cnt_line_wr,
  output logic [31:0]            cnt_stall,
`endif
  output bridge_state_t          dbg_state
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

  bridge_state_t          state, state_d;
  logic [LINE_ADDR_W-1:0] addr_q;
  logic [3:0]             be_pend;      // enabled words not yet written
  logic [LINE_W-1:0]      wdata_q;
  logic [BEAT_CNT_W-1:0]  rd_beat;      // next read beat to issue
  logic [LINE_W-1:0]      readdata_q;   // last delivered line

  logic [BEAT_CNT_W-1:0]  wr_beat;
  logic [3:0]             wr_onehot;
  logic                   wr_last;
  logic                   asm_clear;
  logic                   asm_full;
  logic [LINE_W-1:0]      asm_line;

  assign wr_beat   = first_enabled(be_pend);
  assign wr_onehot = 4'b0001 << wr_beat;
  assign wr_last   = (be_pend & ~wr_onehot) == 4'b0000;

  // Returned words are only meaningful while a read is outstanding.
  assign asm_clear = !((state == RD_ISSUE) || (state == RD_COLLECT));

  line_assembler #(.WORD_W(WORD_W)) u_asm (
    .clk          (clk),
    .rst          (rst),
    .clear        (asm_clear),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_rdata  (i_mem_rdata),
    .line         (asm_line),
    .full         (asm_full)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  // Next-state and memory-side strobes; write wins over a simultaneous read.
  always_comb begin
    state_d     = state;
    o_mem_re    = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (state)
      IDLE: begin
        if (i_s_write)     state_d = WR;
        else if (i_s_read) state_d = RD_ISSUE;
      end
      WR: begin
        if (be_pend == 4'b0000) begin
          state_d = IDLE;
        end else begin
          o_mem_we    = 1'b1;
          o_mem_addr  = {addr_q, wr_beat};
          o_mem_wdata = line_word(wdata_q, wr_beat);
          if (i_mem_ready && wr_last) state_d = IDLE;
        end
      end
      RD_ISSUE: begin
        o_mem_re   = 1'b1;
        o_mem_addr = {addr_q, rd_beat};
        if (i_mem_ready && (rd_beat == LAST_BEAT))
          state_d = asm_full ? RESP : RD_COLLECT;
      end
      RD_COLLECT: begin
        if (asm_full) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latching, write-mask retirement, read issue counter, line hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q     <= '0;
      be_pend    <= '0;
      wdata_q    <= '0;
      rd_beat    <= '0;
      readdata_q <= '0;
    end else begin
      if (state == IDLE) begin
        rd_beat <= '0;
        if (i_s_write) begin
          addr_q  <= i_s_addr;
          be_pend <= i_s_byte_en;
          wdata_q <= i_s_writedata;
        end else if (i_s_read) begin
          addr_q  <= i_s_addr;
        end
      end
      if ((state == WR) && i_mem_ready && (be_pend != 4'b0000))
        be_pend <= be_pend & ~wr_onehot;
      if ((state == RD_ISSUE) && i_mem_ready)
        rd_beat <= rd_beat + 1'b1;
      if (state == RESP)
        readdata_q <= asm_line;
    end
  end

  assign o_s_waitrequest    = (state != IDLE);
  assign o_s_readdata_valid = (state == RESP);
  assign o_s_readdata       = (state == RESP) ? asm_line : readdata_q;
  assign dbg_state          = state;

`ifdef BRIDGE_STATS_EN
  // Line accept counters and memory stall counter; all wrap at 2^32.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_line_rd <= '0;
      cnt_line_wr <= '0;
      cnt_stall   <= '0;
    end else begin
      if ((state == IDLE) && i_s_read && !i_s_write) cnt_line_rd <= cnt_line_rd + 32'd1;
      if ((state == IDLE) && i_s_write)              cnt_line_wr <= cnt_line_wr + 32'd1;
      if ((o_mem_re || o_mem_we) && !i_mem_ready)    cnt_stall   <= cnt_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Testbench for cache_mem_bridge (optionally built with BRIDGE_STATS_EN).
// Word memory model: unwritten word n reads as 32'hA000_0000 + n.
module tb_cache_mem_bridge;
  import cache_mem_pkg::*;

  logic          clk;
  logic          rst;
  logic [25:0]   i_s_addr;
  logic [3:0]    i_s_byte_en;
  logic [127:0]  i_s_writedata;
  logic          i_s_read;
  logic          i_s_write;
  logic [127:0]  o_s_readdata;
  logic          o_s_readdata_valid;
  logic          o_s_waitrequest;
  logic [27:0]   o_mem_addr;
  logic          o_mem_re;
  logic          o_mem_we;
  logic [31:0]   o_mem_wdata;
  logic          i_mem_ready;
  logic [31:0]   i_mem_rdata;
  logic          i_mem_rvalid;
  bridge_state_t dbg_state;
`ifdef BRIDGE_STATS_EN
  logic [31:0]   cnt_line_rd, cnt_line_wr, cnt_stall;
`endif

  cache_mem_bridge dut (
    .clk                (clk),
    .rst                (rst),
    .i_s_addr           (i_s_addr),
    .i_s_byte_en        (i_s_byte_en),
    .i_s_writedata      (i_s_writedata),
    .i_s_read           (i_s_read),
    .i_s_write          (i_s_write),
    .o_s_readdata       (o_s_readdata),
    .o_s_readdata_valid (o_s_readdata_valid),
    .o_s_waitrequest    (o_s_waitrequest),
    .o_mem_addr         (o_mem_addr),
    .o_mem_re           (o_mem_re),
    .o_mem_we           (o_mem_we),
    .o_mem_wdata        (o_mem_wdata),
    .i_mem_ready        (i_mem_ready),
    .i_mem_rdata        (i_mem_rdata),
    .i_mem_rvalid       (i_mem_rvalid),
`ifdef BRIDGE_STATS_EN
    .cnt_line_rd        (cnt_line_rd),
    .cnt_line_wr        (cnt_line_wr),
    .cnt_stall          (cnt_stall),
`endif
    .dbg_state          (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int t0 = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference data ----------------
  logic [31:0] gold [logic [27:0]];
  logic [31:0] mem  [logic [27:0]];

  function automatic logic [31:0] gold_word(input logic [27:0] a);
    return gold.exists(a) ? gold[a] : (32'hA000_0000 + {4'h0, a});
  endfunction

  function automatic logic [31:0] mem_word(input logic [27:0] a);
    return mem.exists(a) ? mem[a] : (32'hA000_0000 + {4'h0, a});
  endfunction

  logic [59:0]  exp_wr_q[$];    // {word addr, data} per expected write beat
  logic [27:0]  exp_rd_q[$];    // word addr per expected read beat
  logic [127:0] exp_line_q[$];  // expected delivered lines
  int exp_rd_cnt = 0;
  int exp_wr_cnt = 0;

  // ---------------- word memory model ----------------
  logic [31:0] rq_data[$];
  int          rq_due[$];
  int          m_edge   = 0;
  int          mem_lat  = 1;
  int          wr_beats = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      rq_data.delete();
      rq_due.delete();
      i_mem_rvalid <= 1'b0;
      i_mem_rdata  <= '0;
    end else begin
      if (o_mem_we && i_mem_ready) begin
        mem[o_mem_addr] = o_mem_wdata;
        wr_beats++;
      end
      if (o_mem_re && i_mem_ready) begin
        rq_data.push_back(mem_word(o_mem_addr));
        rq_due.push_back(m_edge + mem_lat - 1);
      end
      if (rq_due.size() > 0 && rq_due[0] <= m_edge) begin
        i_mem_rvalid <= 1'b1;
        i_mem_rdata  <= rq_data.pop_front();
        void'(rq_due.pop_front());
      end else begin
        i_mem_rvalid <= 1'b0;
      end
      m_edge++;
    end
  end

  // ---------------- scoreboard / compare ----------------
  logic        prev_stall = 1'b0;
  logic [61:0] prev_bus   = '0;

  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (o_mem_re && o_mem_we) check("strobe_exclusive", 1'b1, 1'b0);
      if (o_mem_we && i_mem_ready) begin
        if (exp_wr_q.size() == 0) check("unexpected_we", {o_mem_addr, o_mem_wdata}, 0);
        else check("wr_beat", {o_mem_addr, o_mem_wdata}, exp_wr_q.pop_front());
      end
      if (o_mem_re && i_mem_ready) begin
        if (exp_rd_q.size() == 0) check("unexpected_re", o_mem_addr, 0);
        else check("rd_beat_addr", o_mem_addr, exp_rd_q.pop_front());
      end
      if (prev_stall)
        check("stall_hold", {o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata}, prev_bus);
      prev_stall = (o_mem_re || o_mem_we) && !i_mem_ready;
      prev_bus   = {o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata};
      if (o_s_readdata_valid) begin
        if (exp_line_q.size() == 0) check("unexpected_valid", o_s_readdata, 0);
        else check("read_line", o_s_readdata, exp_line_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1: drives the request for cycle 0, returns in cycle 1.
  task automatic issue(input logic rd, input logic wr, input logic [25:0] a,
                       input logic [3:0] be, input logic [127:0] wd);
    logic [127:0] ln;
    check("idle_before_issue", o_s_waitrequest, 1'b0);
    t0            = edge_n;
    i_s_read      = rd;
    i_s_write     = wr;
    i_s_addr      = a;
    i_s_byte_en   = be;
    i_s_writedata = wd;
    if (wr) begin
      exp_wr_cnt++;
      for (int k = 0; k < 4; k++) begin
        if (be[k]) begin
          exp_wr_q.push_back({a, k[1:0], wd[32*k +: 32]});
          gold[{a, k[1:0]}] = wd[32*k +: 32];
        end
      end
    end else if (rd) begin
      exp_rd_cnt++;
      for (int k = 0; k < 4; k++) begin
        exp_rd_q.push_back({a, k[1:0]});
        ln[32*k +: 32] = gold_word({a, k[1:0]});
      end
      exp_line_q.push_back(ln);
    end
    @(posedge clk); #1;
    i_s_read  = 1'b0;
    i_s_write = 1'b0;
  endtask

  task automatic wait_valid(output int cyc, output logic [127:0] data);
    cyc  = -1;
    data = '0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (o_s_readdata_valid) begin
        cyc  = edge_n - t0;
        data = o_s_readdata;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(output int cyc);
    cyc = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (!o_s_waitrequest) begin
        cyc = edge_n - t0;
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_waitreq"}, o_s_waitrequest, 1'b0);
    check({name, "_valid"}, o_s_readdata_valid, 1'b0);
    check({name, "_readdata"}, o_s_readdata, 128'h0);
    check({name, "_mem_bus"}, {o_mem_re, o_mem_we, o_mem_addr, o_mem_wdata}, 62'h0);
    check({name, "_state"}, dbg_state, IDLE);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int           cyc;
    int           wb0;
    logic [127:0] data;

    rst = 1'b0; i_s_addr = '0; i_s_byte_en = '0; i_s_writedata = '0;
    i_s_read = 1'b0; i_s_write = 1'b0; i_mem_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
`ifdef BRIDGE_STATS_EN
    check("reset_stats", {cnt_line_rd, cnt_line_wr, cnt_stall}, 96'h0);
`endif
    #2 rst = 1'b1;
    @(posedge clk); #1;

    // Full line read, ready=1, latency 1
    issue(1'b1, 1'b0, 26'h10, 4'h0, '0);
    wait_valid(cyc, data);
    check("read_valid_cycle", cyc, 6);
    check("read_literal", data, 128'hA000_0043_A000_0042_A000_0041_A000_0040);
    check("readdata_hold", o_s_readdata, 128'hA000_0043_A000_0042_A000_0041_A000_0040);

    // Partial write, words 0 and 2 of line 3
    wb0 = wr_beats;
    issue(1'b0, 1'b1, 26'h3, 4'b0101, 128'hD0D0_0003_D0D0_0002_D0D0_0001_D0D0_0000);
    wait_idle(cyc);
    check("pwrite_idle_cycle", cyc, 3);
    check("pwrite_beats", wr_beats - wb0, 2);
    check("pwrite_mem_0C", mem_word(28'h0C), 32'hD0D0_0000);
    check("pwrite_mem_0E", mem_word(28'h0E), 32'hD0D0_0002);
    issue(1'b1, 1'b0, 26'h3, 4'h0, '0);
    wait_valid(cyc, data);
    check("readback_cycle", cyc, 6);
    check("readback_literal", data, 128'hA000_000F_D0D0_0002_A000_000D_D0D0_0000);

    // Write with no words enabled
    wb0 = wr_beats;
    issue(1'b0, 1'b1, 26'h4, 4'b0000, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF);
    wait_idle(cyc);
    check("be0_idle_cycle", cyc, 2);
    check("be0_beats", wr_beats - wb0, 0);

    // Simultaneous read and write: write wins, read dropped
    wb0 = wr_beats;
    issue(1'b1, 1'b1, 26'h5, 4'b1111, 128'h5555_0003_5555_0002_5555_0001_5555_0000);
    wait_idle(cyc);
    check("rw_idle_cycle", cyc, 5);
    repeat (4) @(posedge clk);
    #1;
    check("rw_beats", wr_beats - wb0, 4);
    check("rw_mem_17", mem_word(28'h17), 32'h5555_0003);
`ifdef BRIDGE_STATS_EN
    check("rw_cnt_line_rd", cnt_line_rd, exp_rd_cnt);
    check("rw_cnt_line_wr", cnt_line_wr, exp_wr_cnt);
    check("rw_cnt_stall", cnt_stall, 0);
`endif

    // Backpressure: ready low for 3 cycles on read beat 2
    issue(1'b1, 1'b0, 26'h10, 4'h0, '0);
    @(posedge clk); #1;          // cycle 2
    @(posedge clk); #1;          // cycle 3
    i_mem_ready = 1'b0;
    @(negedge clk);
    check("bp_beat2_bus", {o_mem_re, o_mem_addr}, {1'b1, 28'h42});
    repeat (3) @(posedge clk);
    #1;                          // cycle 6
    i_mem_ready = 1'b1;
    wait_valid(cyc, data);
    check("bp_valid_cycle", cyc, 9);
    check("bp_literal", data, 128'hA000_0043_A000_0042_A000_0041_A000_0040);
`ifdef BRIDGE_STATS_EN
    check("bp_cnt_stall", cnt_stall, 3);
    check("bp_cnt_line_rd", cnt_line_rd, exp_rd_cnt);
`endif

    // Reset in RD_COLLECT after two returned words (latency 3)
    mem_lat = 3;
    issue(1'b1, 1'b0, 26'h20, 4'h0, '0);
    repeat (5) @(posedge clk);
    #1;                          // cycle 6
    check("mid_state", dbg_state, RD_COLLECT);
    #2 rst = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_line_q.delete();
    exp_rd_q.delete();
    exp_rd_cnt = 0;
    exp_wr_cnt = 0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    mem_lat = 1;
    @(posedge clk); #1;
    issue(1'b1, 1'b0, 26'h20, 4'h0, '0);
    wait_valid(cyc, data);
    check("post_reset_cycle", cyc, 6);
    check("post_reset_literal", data, 128'hA000_0083_A000_0082_A000_0081_A000_0080);
`ifdef BRIDGE_STATS_EN
    check("post_reset_cnt_rd", cnt_line_rd, exp_rd_cnt);
    check("post_reset_cnt_wr", cnt_line_wr, exp_wr_cnt);
`endif

    repeat (3) @(posedge clk);
    #1;
    check("exp_wr_q_empty", exp_wr_q.size(), 0);
    check("exp_rd_q_empty", exp_rd_q.size(), 0);
    check("exp_line_q_empty", exp_line_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
